// File: rtl/alu_pkg.sv
// Shared opcodes, opcode width and handshake FSM state encodings for the ALU slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_WIDTH-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_WIDTH-1:0] ALU_NOT  = 4'd2;
  localparam logic [OP_WIDTH-1:0] ALU_AND  = 4'd3;
  localparam logic [OP_WIDTH-1:0] ALU_OR   = 4'd4;
  localparam logic [OP_WIDTH-1:0] ALU_XOR  = 4'd5;
  localparam logic [OP_WIDTH-1:0] ALU_SLTU = 4'd6;
  localparam logic [OP_WIDTH-1:0] ALU_EQ   = 4'd7;
  localparam logic [OP_WIDTH-1:0] ALU_SLT  = 4'd8;
  localparam logic [OP_WIDTH-1:0] ALU_SLL  = 4'd9;
  localparam logic [OP_WIDTH-1:0] ALU_SRL  = 4'd10;
  localparam logic [OP_WIDTH-1:0] ALU_SRA  = 4'd11;
  localparam logic [OP_WIDTH-1:0] ALU_MUL  = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand source and the ALU.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] Ai;
  logic [DATA_WIDTH-1:0] Bi;
  logic [OP_WIDTH-1:0]   op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] Result;
  logic                  Overflow;
  logic                  Cout;
  logic                  Zero;
  logic                  Illegal;

  modport master (
    output in_valid, Ai, Bi, op, out_ready,
    input  in_ready, out_valid, Result, Overflow, Cout, Zero, Illegal
  );

  modport slave (
    input  in_valid, Ai, Bi, op, out_ready,
    output in_ready, out_valid, Result, Overflow, Cout, Zero, Illegal
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier keeping the low DATA_WIDTH bits of the product.
// Latency: i_start edge, then DATA_WIDTH step edges; o_done is high in the cycle after the last step.
// Backpressure: none; the caller must not pulse i_start while a multiply is running.
module alu_mul_iter #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_product
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_cnt;
  logic                  r_run;

  // Load operands on start, then one add-and-shift step per clock until the counter expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= '0;
      r_cnt <= CW'(DATA_WIDTH);
      r_run <= 1'b1;
    end else if (r_run) begin
      if (r_cnt != '0) begin
        if (r_b[0]) r_acc <= r_acc + r_a;
        r_a   <= r_a << 1;
        r_b   <= r_b >> 1;
        r_cnt <= r_cnt - CW'(1);
      end else begin
        // Product has been handed over this cycle.
        r_run <= 1'b0;
      end
    end
  end

  assign o_done    = r_run & (r_cnt == '0);
  assign o_product = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; optional iterative MUL when ALU_MUL_EN is defined.
// Latency: 1 clk for single-cycle ops, DATA_WIDTH+1 clk for MUL; one op in flight.
// Backpressure: result held stable while out_valid & !out_ready; in_ready low in BUSY or stalled HOLD.
module alu_seq
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);

  localparam int                  M    = DATA_WIDTH - 1;
  localparam logic [DATA_WIDTH:0] LP_W = (DATA_WIDTH + 1)'(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_is_mul;
  logic                  w_mul_start;
  logic                  w_mul_done;
  logic [DATA_WIDTH-1:0] w_mul_prod;

  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_big;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ovf;
  logic                  w_cout;
  logic                  w_ill;

  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_ovf;
  logic                  r_cout;
  logic                  r_zero;
  logic                  r_ill;

  assign w_a         = bus.Ai;
  assign w_b         = bus.Bi;
  assign w_in_ready  = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & bus.out_ready);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_mul_start = w_accept & w_is_mul;

`ifdef ALU_MUL_EN
  assign w_is_mul = (bus.op == ALU_MUL);

  alu_mul_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`else
  // Without the multiplier, op 12 takes the reserved-op path and BUSY is never entered.
  assign w_is_mul   = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: accept from IDLE or a draining HOLD, leave BUSY when the multiplier finishes.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_is_mul ? ST_BUSY : ST_HOLD;
      ST_BUSY: if (w_mul_done) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_accept)           w_state_nxt = w_is_mul ? ST_BUSY : ST_HOLD;
        else if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Single-cycle op mux; MUL and reserved codes fall to the Illegal default here.
  always_comb begin
    w_sum  = '0;
    w_res  = '0;
    w_ovf  = 1'b0;
    w_cout = 1'b0;
    w_ill  = 1'b0;
    w_big  = ({1'b0, w_b} >= LP_W);
    case (bus.op)
      ALU_ADD: begin
        w_sum  = {1'b0, w_a} + {1'b0, w_b};
        w_res  = w_sum[M:0];
        w_cout = w_sum[DATA_WIDTH];
        w_ovf  = (w_a[M] == w_b[M]) & (w_sum[M] != w_a[M]);
      end
      ALU_SUB: begin
        w_sum  = {1'b0, w_a} + {1'b0, ~w_b} + (DATA_WIDTH + 1)'(1);
        w_res  = w_sum[M:0];
        w_cout = w_sum[DATA_WIDTH];
        w_ovf  = (w_a[M] != w_b[M]) & (w_sum[M] != w_a[M]);
      end
      ALU_NOT:  w_res = ~w_a;
      ALU_AND:  w_res = w_a & w_b;
      ALU_OR:   w_res = w_a | w_b;
      ALU_XOR:  w_res = w_a ^ w_b;
      ALU_SLTU: w_res = {{M{1'b0}}, (w_a < w_b)};
      ALU_EQ:   w_res = {{M{1'b0}}, (w_a == w_b)};
      ALU_SLT:  w_res = {{M{1'b0}}, ($signed(w_a) < $signed(w_b))};
      ALU_SLL:  w_res = w_big ? '0 : (w_a << w_b);
      ALU_SRL:  w_res = w_big ? '0 : (w_a >> w_b);
      ALU_SRA:  w_res = w_big ? {DATA_WIDTH{w_a[M]}} : $unsigned($signed(w_a) >>> w_b);
      default:  w_ill = 1'b1;
    endcase
  end

  // Result/flag registers: load at accept of a single-cycle op or when the multiplier finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_ill    <= 1'b0;
    end else if (w_accept & ~w_is_mul) begin
      r_result <= w_res;
      r_ovf    <= w_ovf;
      r_cout   <= w_cout;
      r_zero   <= (w_res == '0);
      r_ill    <= w_ill;
    end else if ((r_state == ST_BUSY) & w_mul_done) begin
      r_result <= w_mul_prod;
      r_ovf    <= 1'b0;
      r_cout   <= 1'b0;
      r_zero   <= (w_mul_prod == '0);
      r_ill    <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == ST_HOLD);
  assign bus.Result    = r_result;
  assign bus.Overflow  = r_ovf;
  assign bus.Cout      = r_cout;
  assign bus.Zero      = r_zero;
  assign bus.Illegal   = r_ill;

endmodule
